bus_rr_scheduler: RTL
=====================

# bus_rr_scheduler

Round-robin bus scheduler that shares the single AXI master port of the CPU bus interface among N requesters (instruction fetch, data cache, uncached data). It replaces fixed-owner arbitration with transaction-locked ownership: a granted master keeps the bus until the bus side reports the end of its transaction. Ownership then rotates fairly, with an optional master-0 (data) priority mode and a watchdog that frees a hung owner.

## Interface

- N_MASTER, 3, number of requesters (2..8)
- PRIO0, 0, 1 = master 0 wins every arbitration in which it requests; 0 = pure round robin
- TIMEOUT, 0, cycles an owner may hold the bus without `done`; 0 disables the watchdog (max 65535)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_MASTER  per-master request level, bit i = master i
- done  in  1  one-cycle pulse: current granted transaction completed (last handshake)
- grant  out  N_MASTER  one-hot grant, all zero when idle
- grant_id  out  clog2(N_MASTER)  index of current owner, 0 when idle
- busy  out  1  bus owned (state OWN)
- timeout_err  out  1  one-cycle pulse when watchdog forces release

## Operation

- States: IDLE (no owner), OWN (owner = grant_id).
- Reset values: state IDLE, grant 0, grant_id 0, busy 0, timeout_err 0, last_owner N_MASTER-1 (first pick starts at master 0), watchdog count 0.
- Arbitration point: IDLE with any req bit set, or OWN with `done` (or watchdog expiry).
- Pick rule: PRIO0=1 and req[0] -> master 0. Otherwise the first set req bit searching last_owner+1, last_owner+2, … wrapping modulo N_MASTER; last_owner itself is searched last, so it wins only when it is the sole requester.
- At an arbitration point with a winner: state OWN, grant/grant_id = winner, last_owner = winner. With no winner: state IDLE, grant 0.
- In OWN without done: grant held unchanged regardless of req; an owner dropping req does not release the bus.
- done in IDLE is ignored. done on the same edge as rst: reset wins.
- Watchdog (TIMEOUT>0): counter clears on entry to OWN and on every arbitration; it increments each OWN cycle without done. When it reaches TIMEOUT-1 without done, that cycle is treated as an arbitration point, timeout_err pulses on the following cycle, and the timed-out owner is searched last.
- Reset asserted mid-transaction: grant drops asynchronously to 0; no completion is implied.

## Timing

- All outputs registered; no combinational path from req/done to grant.
- IDLE, req set at edge t -> grant valid from edge t+1.
- done sampled at edge t -> new grant (or 0) from edge t+1; back-to-back handover has no idle cycle.
- grant is always one-hot or zero; grant_id matches grant; busy = |grant.
- timeout_err is high exactly one cycle, aligned with the new grant.

## Structure

- Shared package `bus_pkg`: state enum (IDLE, OWN), MASTER_ID_W = clog2(N_MASTER) function, WDOG_W = 16.
- Sub-module `rr_pick`: combinational rotate-mask-priority-encode; inputs req and last_owner, outputs valid and index. The top holds the FSM, the last_owner register, the watchdog, and the PRIO0 override.

## Test plan

- Reset, then req=3'b111 -> grant 001 at the next edge; done -> 010; done -> 100; done -> 001 (rotation with no bubble).
- Owner 1 drops req mid-transaction with req=3'b101 -> grant stays 010 until done, then moves to 100.
- PRIO0=1, req=3'b111 held, three done pulses -> grant stays 001 every time; req[0] drops -> next done grants 010.
- Sole requester master 2 -> repeated done pulses keep grant 100 each cycle; done while IDLE -> no change.
- TIMEOUT=8, owner 0 never sees done, req=3'b011 -> after 8 OWN cycles grant moves to 010 and timeout_err pulses once.
- rst asserted mid-OWN between clock edges -> grant, busy and grant_id clear immediately; after release, req=3'b100 -> grant 100 (last_owner reset to 2, so master 2 wins as sole requester).

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the round-robin bus scheduler.
// Holds the ownership state encoding and width helpers used by all blocks.
package bus_pkg;

  localparam int WDOG_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } bus_state_e;

  // Width of a master index; a single requester pair still needs one bit.
  function automatic int master_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after last_owner wins,
// with last_owner itself considered last.
module rr_pick
  import bus_pkg::*;
#(
  parameter int N_MASTER = 3
) (
  input  logic [N_MASTER-1:0]              req,
  input  logic [master_id_w(N_MASTER)-1:0] last_owner,
  output logic                             valid,
  output logic [master_id_w(N_MASTER)-1:0] index
);

  localparam int ID_W = master_id_w(N_MASTER);

  logic [N_MASTER-1:0] above;
  logic [N_MASTER-1:0] masked;

  // Requesters strictly above last_owner take precedence; if none, wrap to the
  // lowest requester overall, which reaches last_owner only when it is alone.
  always_comb begin
    // NOTE: every output and temporary gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    above = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      above[i] = (ID_W'(i) > last_owner);
    end
    masked = req & above;
    valid  = |req;
    index  = '0;
    if (|masked) begin
      for (int i = N_MASTER - 1; i >= 0; i--) begin
        if (masked[i]) index = ID_W'(i);
      end
    end else begin
      for (int i = N_MASTER - 1; i >= 0; i--) begin
        if (req[i]) index = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Transaction-locked round-robin owner of the CPU bus master port, with an
// optional master-0 priority override and a watchdog that frees a hung owner.
module bus_rr_scheduler
  import bus_pkg::*;
#(
  parameter int N_MASTER = 3,
  parameter int PRIO0    = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_MASTER-1:0]              req,
  input  logic                             done,
  output logic [N_MASTER-1:0]              grant,
  output logic [master_id_w(N_MASTER)-1:0] grant_id,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int ID_W = master_id_w(N_MASTER);

  bus_state_e        state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [WDOG_W-1:0] cnt_q, cnt_d;
  logic              terr_q, terr_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_idx;
  logic              prio_hit;
  logic              win_valid;
  logic [ID_W-1:0]   win_idx;
  logic              wdog_exp;
  logic              arb;

  rr_pick #(.N_MASTER(N_MASTER)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // State register; last_owner starts at the top index so master 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(N_MASTER - 1);
      cnt_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
    end
  end

  // Next-state logic: arbitrate when idle, on done, or when the watchdog expires.
  always_comb begin
    prio_hit  = (PRIO0 != 0) && req[0];
    win_valid = prio_hit || pick_valid;
    win_idx   = prio_hit ? '0 : pick_idx;
    wdog_exp  = (TIMEOUT > 0) && (state_q == OWN) && !done &&
                (cnt_q == WDOG_W'(TIMEOUT - 1));
    arb       = (state_q == IDLE) || done || wdog_exp;

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;

    if (arb) begin
      cnt_d  = '0;
      terr_d = wdog_exp;
      if (win_valid) begin
        state_d = OWN;
        owner_d = win_idx;
        last_d  = win_idx;
      end else begin
        state_d = IDLE;
        owner_d = '0;
      end
    end else if ((state_q == OWN) && (TIMEOUT > 0)) begin
      cnt_d = cnt_q + WDOG_W'(1);
    end
  end

  // Output decode from registered state only; req/done never reach grant directly.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      grant[i] = (state_q == OWN) && (owner_q == ID_W'(i));
    end
    busy        = (state_q == OWN);
    grant_id    = owner_q;
    timeout_err = terr_q;
  end

endmodule
